// File: rtl/hella_cache_responder_bfm.sv
// ---- hella_cache_responder_bfm : memory-side HellaCache responder BFM, rev 1.0          ----
// ---- periodic nacking is built only when HELLA_CACHE_RESPONDER_NACK_EN is defined       ----
`default_nettype none

module hella_cache_responder_bfm #(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_TAG_BITS  = 7,
  parameter int MEM_WORDS     = 1024,
  parameter int RSP_LATENCY   = 2,
  parameter int NACK_PERIOD   = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_ADDR_BITS-1:0]   req_addr,
  output logic                       req_ready,
  input  logic                       req_valid,
  input  logic [NUM_TAG_BITS-1:0]    req_tag,
  input  logic [4:0]                 req_cmd,
  input  logic [2:0]                 req_typ,
  input  logic [NUM_DATA_BITS-1:0]   req_data,
  input  logic [NUM_DATA_BITS/8-1:0] req_data_mask,
  input  logic                       req_kill,
  output logic                       rsp_valid,
  output logic                       rsp_nack,
  output logic [NUM_TAG_BITS-1:0]    rsp_tag,
  output logic [2:0]                 rsp_typ,
  output logic [NUM_DATA_BITS-1:0]   rsp_data
);

  localparam int NB     = NUM_DATA_BITS / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int WAIT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam logic [4:0] CMD_LOAD  = 5'd0;
  localparam logic [4:0] CMD_STORE = 5'd1;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_NACK, S_WAIT, S_RESP} state_t;

  state_t                     state;
  logic [NUM_ADDR_BITS-1:0]   r_addr;
  logic [NUM_TAG_BITS-1:0]    r_tag;
  logic [4:0]                 r_cmd;
  logic [2:0]                 r_typ;
  logic [NUM_DATA_BITS-1:0]   r_data;
  logic [NB-1:0]              r_mask;
  logic [WAIT_W-1:0]          r_wait;
  logic [NUM_DATA_BITS-1:0]   mem [MEM_WORDS];

  logic [IDX_W-1:0]           w_idx;
  logic [2:0]                 w_lg;
  logic [OFF_W-1:0]           w_off;
  logic [NUM_DATA_BITS-1:0]   w_shift;
  logic [NUM_DATA_BITS-1:0]   w_load;
  logic [NUM_DATA_BITS-1:0]   w_rsp_data;
  logic                       w_sign;
  logic                       w_nack_hit;
  logic                       unused_addr;

  // Address bits above the word index are deliberately ignored so addresses wrap.
  assign w_idx       = r_addr[OFF_W +: IDX_W];
  assign unused_addr = ^r_addr;

`ifdef HELLA_CACHE_RESPONDER_NACK_EN
  localparam int CNT_W = (NACK_PERIOD > 2) ? $clog2(NACK_PERIOD) : 1;
  logic [CNT_W-1:0] r_nack_cnt;
  assign w_nack_hit = (r_nack_cnt == CNT_W'(NACK_PERIOD - 1));
`else
  logic unused_cfg;
  assign w_nack_hit = 1'b0;
  assign unused_cfg = (NACK_PERIOD == 0);
`endif

  // Load path: clamp size to the bus, align the offset down, shift to LSBs, extend.
  always_comb begin
    w_lg    = ({1'b0, r_typ[1:0]} > 3'(OFF_W)) ? 3'(OFF_W) : {1'b0, r_typ[1:0]};
    w_off   = r_addr[OFF_W-1:0] & ~((OFF_W'(1) << w_lg) - OFF_W'(1));
    w_shift = mem[w_idx] >> {w_off, 3'b000};
    w_sign  = 1'b0;
    w_load  = '0;
    for (int b = 0; b < NB; b++) begin
      if (b == (1 << w_lg) - 1) w_sign = w_shift[b*8+7] & ~r_typ[2];
    end
    for (int b = 0; b < NB; b++) begin
      w_load[b*8 +: 8] = (b < (1 << w_lg)) ? w_shift[b*8 +: 8] : {8{w_sign}};
    end
    w_rsp_data = (r_cmd == CMD_LOAD) ? w_load : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
      rsp_tag   <= '0;
      rsp_typ   <= '0;
      rsp_data  <= '0;
      r_wait    <= '0;
      r_addr    <= '0;
      r_tag     <= '0;
      r_cmd     <= '0;
      r_typ     <= '0;
      r_data    <= '0;
      r_mask    <= '0;
`ifdef HELLA_CACHE_RESPONDER_NACK_EN
      r_nack_cnt <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_addr    <= req_addr;
            r_tag     <= req_tag;
            r_cmd     <= req_cmd;
            r_typ     <= req_typ;
            r_data    <= req_data;
            r_mask    <= req_data_mask;
            req_ready <= 1'b0;
            state     <= S_DATA;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_DATA: begin
          if (req_kill) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            rsp_nack <= w_nack_hit;
            state    <= S_NACK;
`ifdef HELLA_CACHE_RESPONDER_NACK_EN
            r_nack_cnt <= w_nack_hit ? '0 : r_nack_cnt + CNT_W'(1);
`endif
          end
        end
        S_NACK: begin
          // rsp_nack is high for exactly this state, so it doubles as the nacked flag.
          if (rsp_nack || r_cmd == CMD_STORE) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else if (RSP_LATENCY == 1) begin
            rsp_valid <= 1'b1;
            rsp_tag   <= r_tag;
            rsp_typ   <= r_typ;
            rsp_data  <= w_rsp_data;
            state     <= S_RESP;
          end else begin
            r_wait <= WAIT_W'(RSP_LATENCY - 1);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == WAIT_W'(1)) begin
            rsp_valid <= 1'b1;
            rsp_tag   <= r_tag;
            rsp_typ   <= r_typ;
            rsp_data  <= w_rsp_data;
            state     <= S_RESP;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Memory is intentionally outside reset; a reset landing on the commit edge blocks the write.
  always_ff @(posedge clock) begin
    if (reset_n && state == S_NACK && r_cmd == CMD_STORE && !rsp_nack) begin
      for (int b = 0; b < NB; b++) begin
        if (r_mask[b]) mem[w_idx][b*8 +: 8] <= r_data[b*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hella_cache_responder_bfm.sv
// ---- tb_hella_cache_responder_bfm : randomized self-checking bench, rev 1.0 ----
`default_nettype none

module tb_hella_cache_responder_bfm;

  localparam int MEM_WORDS   = 16;
  localparam int RSP_LATENCY = 2;
  localparam int NACK_PERIOD = 4;
`ifdef HELLA_CACHE_RESPONDER_NACK_EN
  localparam bit NACK_EN = 1'b1;
`else
  localparam bit NACK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        req_valid = 1'b0;
  logic [6:0]  req_tag = '0;
  logic [4:0]  req_cmd = '0;
  logic [2:0]  req_typ = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_data_mask = '0;
  logic        req_kill = 1'b0;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [6:0]  rsp_tag;
  logic [2:0]  rsp_typ;
  logic [31:0] rsp_data;

  hella_cache_responder_bfm #(
    .NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .NUM_TAG_BITS(7),
    .MEM_WORDS(MEM_WORDS), .RSP_LATENCY(RSP_LATENCY), .NACK_PERIOD(NACK_PERIOD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_addr(req_addr), .req_ready(req_ready),
    .req_valid(req_valid), .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
    .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag), .rsp_typ(rsp_typ),
    .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          to;
    bit          nack;
    int          nrsp;
    int          rsp_at;    // edge (counted from accept) that ends the rsp_valid cycle
    int          ready_at;  // edge after which req_ready is seen again
    logic [31:0] data;
    logic [6:0]  tag;
    logic [2:0]  typ;
  } xres_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          surv = 0;
  logic [31:0] mm [MEM_WORDS];

  function automatic xres_t blank();
    xres_t r;
    r.to = 1'b0; r.nack = 1'b0; r.nrsp = 0; r.rsp_at = -1; r.ready_at = -1;
    r.data = '0; r.tag = '0; r.typ = '0;
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] typ);
    int size, off;
    logic [31:0] v, fmask;
    size = 1 << typ[1:0];
    if (size > 4) size = 4;
    off = int'(addr[1:0]);
    off = off - (off % size);
    v = word >> (8 * off);
    if (size == 4) return v;
    fmask = (32'd1 << (8 * size)) - 32'd1;
    v = v & fmask;
    if (typ[2] == 1'b0 && ((v >> (8 * size - 1)) & 32'd1) == 32'd1) v = v | ~fmask;
    return v;
  endfunction

  // Drives one request and records what the responder did; e is the model's prediction.
  task automatic run_one(input logic [4:0] cmd, input logic [31:0] addr, input logic [2:0] typ,
                         input logic [31:0] data, input logic [3:0] mask, input logic [6:0] tag,
                         input bit kill, output xres_t o, output xres_t e);
    int idx;
    idx = int'((addr >> 2) % MEM_WORDS);
    e = blank();
    e.tag = tag;
    e.typ = typ;
    if (kill) begin
      e.ready_at = 1;
    end else begin
      surv++;
      e.nack = NACK_EN && (surv % NACK_PERIOD == 0);
      if (e.nack) begin
        e.ready_at = 2;
      end else if (cmd == 5'd1) begin
        e.ready_at = 2;
        for (int b = 0; b < 4; b++) if (mask[b]) mm[idx][b*8 +: 8] = data[b*8 +: 8];
      end else begin
        e.nrsp     = 1;
        e.rsp_at   = 2 + RSP_LATENCY;
        e.ready_at = 2 + RSP_LATENCY;
        e.data     = (cmd == 5'd0) ? ref_load(mm[idx], addr, typ) : 32'd0;
      end
    end

    o = blank();
    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clock);
    if (req_ready !== 1'b1) begin
      o.to = 1'b1;
      return;
    end
    req_valid = 1'b1; req_addr = addr; req_cmd = cmd; req_typ = typ;
    req_data = data; req_data_mask = mask; req_tag = tag;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_kill  = kill;
    for (int k = 1; k <= RSP_LATENCY + 6; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 1) begin
        req_kill = 1'b0;
        o.nack = rsp_nack;
      end
      if (rsp_valid === 1'b1) begin
        o.nrsp++;
        o.rsp_at = k + 1;
        o.data = rsp_data; o.tag = rsp_tag; o.typ = rsp_typ;
      end
      if (req_ready === 1'b1) begin
        o.ready_at = k;
        break;
      end
    end
    if (o.ready_at < 0) o.to = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    surv = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b nack=%b tag=%h typ=%h data=%h, want all 0",
               req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data);
    end
    reset_n = 1'b1;
    surv = 0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_fill();
    xres_t o, e;
    for (int w = 0; w < MEM_WORDS; w++) begin
      do begin
        run_one(5'd1, 32'(w * 4), 3'd2, $urandom, 4'hF, 7'(w), 1'b0, o, e);
      end while (e.nack && !o.to);
      n_checks++;
      if (o.to || o.nrsp != 0 || o.ready_at != 2) begin
        n_errors++;
        $display("FAIL fill_store[%0d]: got rsp=%0d ready_at=%0d to=%0d want rsp=0 ready_at=2",
                 w, o.nrsp, o.ready_at, o.to);
      end
    end
  endtask

  task automatic test_store_load();
    xres_t o, e;
    do run_one(5'd1, 32'h100, 3'd2, 32'hDEADBEEF, 4'hF, 7'd1, 1'b0, o, e);
    while (e.nack && !o.to);
    n_checks++;
    if (o.to || o.nrsp != 0) begin
      n_errors++;
      $display("FAIL store_no_rsp: got rsp=%0d to=%0d want rsp=0", o.nrsp, o.to);
    end
    do run_one(5'd0, 32'h100, 3'd2, 32'h0, 4'h0, 7'd5, 1'b0, o, e);
    while (e.nack && !o.to);
    n_checks++;
    if (o.to || o.nrsp != 1 || o.rsp_at != 2 + RSP_LATENCY) begin
      n_errors++;
      $display("FAIL load_latency: got rsp=%0d at edge %0d want 1 at edge %0d",
               o.nrsp, o.rsp_at, 2 + RSP_LATENCY);
    end
    n_checks++;
    if (o.tag !== 7'd5 || o.data !== 32'hDEADBEEF || o.typ !== 3'd2) begin
      n_errors++;
      $display("FAIL load_data: got tag=%0d typ=%0d data=%h want tag=5 typ=2 data=deadbeef",
               o.tag, o.typ, o.data);
    end
  endtask

  task automatic test_sub_word();
    xres_t o, e;
    logic [2:0]  typs [3];
    logic [31:0] want [3];
    typs = '{3'd0, 3'd4, 3'd1};
    want = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080};
    do run_one(5'd1, 32'h80, 3'd2, 32'h0000F080, 4'hF, 7'd2, 1'b0, o, e);
    while (e.nack && !o.to);
    for (int i = 0; i < 3; i++) begin
      do run_one(5'd0, 32'h80, typs[i], 32'h0, 4'h0, 7'(10 + i), 1'b0, o, e);
      while (e.nack && !o.to);
      n_checks++;
      if (o.to || o.nrsp != 1 || o.data !== want[i] || e.data !== want[i]) begin
        n_errors++;
        $display("FAIL sub_word[typ=%0d]: got rsp=%0d data=%h want %h", typs[i], o.nrsp, o.data, want[i]);
      end
    end
  endtask

  task automatic test_kill();
    xres_t o, e;
    logic [31:0] pre;
    pre = $urandom;
    do run_one(5'd1, 32'h40, 3'd2, pre, 4'hF, 7'd3, 1'b0, o, e);
    while (e.nack && !o.to);
    run_one(5'd1, 32'h40, 3'd2, 32'h12345678, 4'hF, 7'd4, 1'b1, o, e);
    n_checks++;
    if (o.to || o.nrsp != 0 || o.nack || o.ready_at != 1) begin
      n_errors++;
      $display("FAIL kill: got rsp=%0d nack=%0d ready_at=%0d want rsp=0 nack=0 ready_at=1",
               o.nrsp, o.nack, o.ready_at);
    end
    do run_one(5'd0, 32'h40, 3'd2, 32'h0, 4'h0, 7'd6, 1'b0, o, e);
    while (e.nack && !o.to);
    n_checks++;
    if (o.to || o.nrsp != 1 || o.data !== pre) begin
      n_errors++;
      $display("FAIL kill_no_write: got rsp=%0d data=%h want %h", o.nrsp, o.data, pre);
    end
  endtask

  task automatic test_nack();
    xres_t o, e;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      run_one(5'd0, a, 3'd2, 32'h0, 4'h0, 7'(20 + i), 1'b0, o, e);
      n_checks++;
      if (o.to || o.nack !== (NACK_EN && i == 3) || o.nrsp != ((NACK_EN && i == 3) ? 0 : 1)) begin
        n_errors++;
        $display("FAIL nack_seq[%0d]: got nack=%0d rsp=%0d want nack=%0d", i, o.nack, o.nrsp,
                 NACK_EN && i == 3);
      end
    end
    run_one(5'd0, a, 3'd2, 32'h0, 4'h0, 7'd23, 1'b0, o, e);
    n_checks++;
    if (o.to || o.nack || o.nrsp != 1 || o.data !== e.data || o.tag !== 7'd23) begin
      n_errors++;
      $display("FAIL nack_reissue: got nack=%0d rsp=%0d data=%h tag=%0d want nack=0 rsp=1 data=%h tag=23",
               o.nack, o.nrsp, o.data, o.tag, e.data);
    end
    for (int i = 0; i < 4; i++) begin
      run_one(5'd0, $urandom, 3'd2, 32'h0, 4'h0, 7'(30 + i), 1'b0, o, e);
      n_checks++;
      if (o.to || o.nack !== e.nack) begin
        n_errors++;
        $display("FAIL nack_restart[%0d]: got nack=%0d want %0d", i, o.nack, e.nack);
      end
    end
  endtask

  task automatic test_wrap();
    xres_t o, e;
    do run_one(5'd1, 32'((MEM_WORDS + 3) * 4), 3'd2, 32'hA5A5A5A5, 4'hF, 7'd7, 1'b0, o, e);
    while (e.nack && !o.to);
    do run_one(5'd0, 32'(3 * 4), 3'd2, 32'h0, 4'h0, 7'd8, 1'b0, o, e);
    while (e.nack && !o.to);
    n_checks++;
    if (o.to || o.nrsp != 1 || o.data !== 32'hA5A5A5A5) begin
      n_errors++;
      $display("FAIL wrap: got rsp=%0d data=%h want a5a5a5a5", o.nrsp, o.data);
    end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    do_reset();
    seen = 0;
    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h0; req_cmd = 5'd0; req_typ = 3'd2; req_tag = 7'd9;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_in_wait: got ready=%b valid=%b nack=%b tag=%h typ=%h data=%h, want all 0",
               req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data);
    end
    reset_n = 1'b1;
    surv = 0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_wait_ready: got %b want 1", req_ready);
    end
    for (int k = 0; k < RSP_LATENCY + 3; k++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clock);
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL reset_in_wait_no_rsp: got %0d responses want 0", seen);
    end
  endtask

  task automatic test_random();
    xres_t o, e;
    logic [4:0] cmd;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      cmd = (r < 4) ? 5'd0 : (r < 8) ? 5'd1 : 5'($urandom_range(2, 31));
      run_one(cmd, $urandom, 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
              7'($urandom_range(0, 127)), $urandom_range(0, 9) == 0, o, e);
      n_checks++;
      if (o.to || o.ready_at != e.ready_at) begin
        n_errors++;
        $display("FAIL rand_ready[%0d]: got ready_at=%0d to=%0d want %0d", i, o.ready_at, o.to, e.ready_at);
      end
      n_checks++;
      if (o.nack !== e.nack || o.nrsp != e.nrsp || o.rsp_at != e.rsp_at) begin
        n_errors++;
        $display("FAIL rand_ctrl[%0d]: got nack=%0d rsp=%0d at %0d want nack=%0d rsp=%0d at %0d",
                 i, o.nack, o.nrsp, o.rsp_at, e.nack, e.nrsp, e.rsp_at);
      end
      if (e.nrsp == 1) begin
        n_checks++;
        if (o.data !== e.data || o.tag !== e.tag || o.typ !== e.typ) begin
          n_errors++;
          $display("FAIL rand_rsp[%0d]: got data=%h tag=%0d typ=%0d want data=%h tag=%0d typ=%0d",
                   i, o.data, o.tag, o.typ, e.data, e.tag, e.typ);
        end
      end
    end
  endtask

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) mm[w] = '0;
    test_reset();
    test_fill();
    test_store_load();
    test_sub_word();
    test_kill();
    test_nack();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
